// File: rtl/multi_pulse_counter.sv
// rtl/multi_pulse_counter.sv - multi-channel gated edge counter with saturating counts and valid/ack result handshake
// Optional 2-flop input synchronizer per channel enabled by PULSE_COUNTER_SYNC_EN.
module multi_pulse_counter #(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int GATE_WIDTH  = 28,
    parameter int GATE_CYCLES = 200_000_000
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [CHANNELS-1:0]           pulse_in,
    input  logic [1:0]                    edge_sel_in,
    input  logic                          ack_in,
    output logic [CHANNELS*CNT_WIDTH-1:0] count_out,
    output logic [CHANNELS-1:0]           ovf_out,
    output logic                          valid_out,
    output logic                          overrun_out
);

    localparam logic [GATE_WIDTH-1:0] LP_GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]  LP_CNT_MAX   = '1;

    logic [GATE_WIDTH-1:0]          r_gate;
    logic [CHANNELS-1:0]            r_prv;
    logic [CHANNELS-1:0]            r_sticky;
    logic [CHANNELS*CNT_WIDTH-1:0]  r_acc;
    logic [CHANNELS*CNT_WIDTH-1:0]  r_count;
    logic [CHANNELS-1:0]            r_ovf;
    logic                           r_valid;
    logic                           r_overrun;

    logic [CHANNELS-1:0]            w_cur;
    logic [CHANNELS-1:0]            w_event;
    logic [CHANNELS-1:0]            w_sticky_nxt;
    logic [CHANNELS*CNT_WIDTH-1:0]  w_acc_nxt;
    logic                           w_wend;

`ifdef PULSE_COUNTER_SYNC_EN
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pulse_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_cur = r_sync2;
`else
    assign w_cur = pulse_in;
`endif

    assign w_wend = (r_gate == LP_GATE_LAST);

    always_comb begin
        w_event = '0;
        case (edge_sel_in)
            2'b00:   w_event = w_cur & ~r_prv;
            2'b01:   w_event = ~w_cur & r_prv;
            2'b10:   w_event = w_cur ^ r_prv;
            default: w_event = '0;
        endcase
    end

    // A full accumulator holds its value and records the lost event in the sticky bit.
    always_comb begin
        w_acc_nxt    = r_acc;
        w_sticky_nxt = r_sticky;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_event[i]) begin
                if (r_acc[i*CNT_WIDTH +: CNT_WIDTH] == LP_CNT_MAX) begin
                    w_sticky_nxt[i] = 1'b1;
                end else begin
                    w_acc_nxt[i*CNT_WIDTH +: CNT_WIDTH] =
                        r_acc[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_gate    <= '0;
            r_prv     <= '0;
            r_acc     <= '0;
            r_sticky  <= '0;
            r_count   <= '0;
            r_ovf     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_prv <= w_cur;
            if (w_wend) begin
                r_gate   <= '0;
                r_count  <= w_acc_nxt;
                r_ovf    <= w_sticky_nxt;
                r_acc    <= '0;
                r_sticky <= '0;
                r_valid  <= 1'b1;
                // A simultaneous ack consumes the old result, so only an unacked one overruns.
                if (r_valid && !ack_in) begin
                    r_overrun <= 1'b1;
                end
            end else begin
                r_gate   <= r_gate + GATE_WIDTH'(1);
                r_acc    <= w_acc_nxt;
                r_sticky <= w_sticky_nxt;
                if (r_valid && ack_in) begin
                    r_valid   <= 1'b0;
                    r_overrun <= 1'b0;
                end
            end
        end
    end

    assign count_out   = r_count;
    assign ovf_out     = r_ovf;
    assign valid_out   = r_valid;
    assign overrun_out = r_overrun;

endmodule

// File: tb/tb_multi_pulse_counter.sv
// tb/tb_multi_pulse_counter.sv - directed scoreboard bench for multi_pulse_counter
module tb_multi_pulse_counter;

`ifdef PULSE_COUNTER_SYNC_EN
    localparam int LP_LAT = 2;
`else
    localparam int LP_LAT = 0;
`endif
    localparam int LP_GATE = 100;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [1:0] pulse_in = '0;
    logic [1:0] edge_sel_in = 2'b00;
    logic       ack_in = 1'b0;
    logic [7:0] count_out;
    logic [1:0] ovf_out;
    logic       valid_out;
    logic       overrun_out;

    typedef struct {
        logic [7:0] cnt;
        logic [1:0] ovf;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   tb_edges = 0;

    multi_pulse_counter #(
        .CHANNELS   (2),
        .CNT_WIDTH  (4),
        .GATE_WIDTH (28),
        .GATE_CYCLES(LP_GATE)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .pulse_in   (pulse_in),
        .edge_sel_in(edge_sel_in),
        .ack_in     (ack_in),
        .count_out  (count_out),
        .ovf_out    (ovf_out),
        .valid_out  (valid_out),
        .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (rst_in) tb_edges <= 0;
        else        tb_edges <= tb_edges + 1;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Saturating 4-bit model of the events each channel should see in one window.
    task automatic push_events(input int e0, input int e1);
        exp_t e;
        e.cnt[3:0] = (e0 > 15) ? 4'd15 : 4'(e0);
        e.cnt[7:4] = (e1 > 15) ? 4'd15 : 4'(e1);
        e.ovf      = {e1 > 15, e0 > 15};
        q_exp.push_back(e);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (q_exp.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = q_exp.pop_front();
            check({tag, "_count"}, {24'd0, count_out}, {24'd0, e.cnt});
            check({tag, "_ovf"}, {30'd0, ovf_out}, {30'd0, e.ovf});
        end
    endtask

    task automatic pulses(input int n0, input int n1);
        int n;
        n = (n0 > n1) ? n0 : n1;
        for (int i = 0; i < n; i++) begin
            pulse_in = {i < n1, i < n0};
            tick();
            pulse_in = 2'b00;
            tick();
        end
    endtask

    task automatic wait_wend(input string tag);
        int guard;
        guard = 0;
        do begin
            tick();
            guard++;
        end while ((tb_edges % LP_GATE) != 0 && guard < 3 * LP_GATE);
        if (guard >= 3 * LP_GATE) check({tag, "_wend_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (tb_edges < target && guard < 3 * LP_GATE) begin
            tick();
            guard++;
        end
    endtask

    task automatic do_ack();
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
    endtask

    initial begin
        int e_base;

        tick();
        tick();
        check("rst_count", {24'd0, count_out}, 32'd0);
        check("rst_ovf", {30'd0, ovf_out}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_overrun", {31'd0, overrun_out}, 32'd0);
        rst_in = 1'b0;

        // Window 1: 5 on ch0, 3 on ch1, no ack.
        pulses(5, 3);
        push_events(5, 3);
        wait_wend("w1");
        check("w1_valid", {31'd0, valid_out}, 32'd1);
        check("w1_overrun", {31'd0, overrun_out}, 32'd0);
        check_result("w1");

        // Window 2: still no ack, so the result is overwritten.
        pulses(2, 1);
        push_events(2, 1);
        wait_wend("w2");
        check("w2_valid", {31'd0, valid_out}, 32'd1);
        check("w2_overrun", {31'd0, overrun_out}, 32'd1);
        check_result("w2");
        do_ack();
        check("ack_valid", {31'd0, valid_out}, 32'd0);
        check("ack_overrun", {31'd0, overrun_out}, 32'd0);
        do_ack();
        check("idle_ack_valid", {31'd0, valid_out}, 32'd0);

        // Window 3: saturation on ch0.
        pulses(20, 0);
        push_events(20, 0);
        wait_wend("w3");
        check_result("w3");
        do_ack();

        // Window 4: counts restart from zero.
        push_events(0, 0);
        wait_wend("w4");
        check_result("w4");
        do_ack();

        // Window 5: both edges.
        edge_sel_in = 2'b10;
        pulses(4, 0);
        push_events(8, 0);
        wait_wend("w5");
        check_result("w5");
        do_ack();

        // Window 6: counting disabled.
        edge_sel_in = 2'b11;
        pulses(4, 2);
        push_events(0, 0);
        wait_wend("w6");
        check_result("w6");
        do_ack();
        edge_sel_in = 2'b00;

        // Window 7: leave result pending for the simultaneous case.
        pulses(1, 0);
        push_events(1, 0);
        wait_wend("w7");
        check("w7_valid", {31'd0, valid_out}, 32'd1);
        check_result("w7");

        // Window 8: ack and a ch0 event both land on the wend edge.
        e_base = tb_edges;
        pulses(2, 0);
        run_to(e_base + LP_GATE - 1 - LP_LAT);
        pulse_in = 2'b01;
        run_to(e_base + LP_GATE - 1);
        ack_in = 1'b1;
        push_events(3, 0);
        tick();
        ack_in = 1'b0;
        check("w8_at_wend", tb_edges, e_base + LP_GATE);
        check("w8_valid", {31'd0, valid_out}, 32'd1);
        check("w8_overrun", {31'd0, overrun_out}, 32'd0);
        check_result("w8");
        tick();
        pulse_in = 2'b00;
        tick();

        // Window 9: reset mid-window discards 3 counted edges.
        pulses(3, 0);
        repeat (6) tick();
        rst_in = 1'b1;
        tick();
        check("mid_rst_count", {24'd0, count_out}, 32'd0);
        check("mid_rst_ovf", {30'd0, ovf_out}, 32'd0);
        check("mid_rst_valid", {31'd0, valid_out}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun_out}, 32'd0);
        rst_in = 1'b0;
        pulses(2, 1);
        push_events(2, 1);
        run_to(LP_GATE - 1);
        check("post_rst_edge99_valid", {31'd0, valid_out}, 32'd0);
        tick();
        check("post_rst_edge100_valid", {31'd0, valid_out}, 32'd1);
        check_result("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_pulse_counter.md
# multi_pulse_counter

Parametrised multi-channel successor to the single-channel pulse counter. Counts edges on `CHANNELS` independent pulse inputs over a fixed gate window of `GATE_CYCLES` clocks. Each channel saturates at its counter width and reports an overflow flag. Results are latched at every window end and delivered through a valid/ack handshake with overrun detection, feeding the LED/segment display and diagnostic logic.

## Interface
- `CHANNELS`, 4: number of independent pulse inputs (1..16).
- `CNT_WIDTH`, 8: per-channel count width in bits.
- `GATE_WIDTH`, 28: width of the gate-window counter.
- `GATE_CYCLES`, 200_000_000: window length in clk_in cycles (2..2^GATE_WIDTH-1).

Ports:
- `clk_in` in 1: sole clock.
- `rst_in` in 1: reset; synchronous, active-high.
- `pulse_in` in CHANNELS: pulse inputs; bit i is channel i.
- `edge_sel_in` in 2: edge mode for all channels. 00 rising, 01 falling, 10 both, 11 counting disabled.
- `ack_in` in 1: consumer acknowledge of the current result.
- `count_out` out CHANNELS*CNT_WIDTH: latched counts. Channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- `ovf_out` out CHANNELS: latched per-channel saturation flags.
- `valid_out` out 1: result available.
- `overrun_out` out 1: an unacknowledged result was overwritten.

## Operation
- Reset (rst_in high at a clk_in edge) clears the following to 0:
  - the gate counter, all accumulators, sticky saturation bits and edge-detect registers;
  - `count_out`, `ovf_out`, `valid_out` and `overrun_out`.
- Reset takes priority over all other activity. Asserting it mid-window discards the partial window; the new window starts at count 0 on the first edge after rst_in deasserts.
- Gate counter runs freely from 0 to GATE_CYCLES-1 and wraps to 0. Window end (`wend`) is the cycle in which the counter equals GATE_CYCLES-1.
- Edge detection, per channel: `cur` is the conditioned input and `prv` is `cur` registered.
  - rising = cur & ~prv
  - falling = ~cur & prv
  - both = cur ^ prv
  - mode 11: no events are counted.
- Edge-detect registers reset to 0. A pulse_in held high through reset release therefore counts as one rising edge.
- Accumulator, per channel:
  - On an event it increments by 1, unless already at 2^CNT_WIDTH-1; in that case it holds and sets that channel's sticky saturation bit.
  - Counts never wrap.
- At `wend`, on the same edge:
  - `count_out` loads each accumulator value including any event counted in the `wend` cycle; `ovf_out` loads the sticky bits.
  - Accumulators and sticky bits clear to 0.
  - `valid_out` is set to 1.
- Handshake:
  - `valid_out` stays high until `ack_in` is sampled high while `valid_out` is 1; `valid_out` clears on that edge.
  - `ack_in` while `valid_out` is 0 is ignored.
  - `count_out` and `ovf_out` hold stable while `valid_out` is 1, except when overwritten at the next `wend`.
- Window end with `valid_out` at 1 and `ack_in` at 0: new results overwrite the old ones, `valid_out` stays 1, and `overrun_out` is set to 1.
- Window end with `valid_out` at 1 and `ack_in` at 1: the ack consumes the old result, the new result loads, `valid_out` stays 1, and `overrun_out` is unchanged.
- `overrun_out` is sticky. It clears only on a consumed ack (with no simultaneous overrun) or on reset.
- An `edge_sel_in` change takes effect on the next cycle's event evaluation.

## Timing
- Window period: exactly GATE_CYCLES clocks. The first `wend` after reset release occurs GATE_CYCLES edges later.
- Event latency with PULSE_COUNTER_SYNC_EN defined: pulse_in transition to accumulator update is 2 edges after first sampling. The transition is sampled at edge k, and the accumulator updates at edge k+2.
- Event latency without the macro: the accumulator updates at edge k, the same edge at which the transition is first sampled.
- Result latency: the `wend` edge updates `count_out`, `ovf_out` and `valid_out` simultaneously; all outputs are registered.
- Minimum pulse width: 1 clk_in cycle high and 1 low for each edge to be counted.

## Configuration
- `PULSE_COUNTER_SYNC_EN` defined:
  - each channel gets a 2-flop synchronizer; `cur` is the second stage;
  - pulse_in may be asynchronous to clk_in;
  - synchronizer flops reset to 0.
- Macro undefined:
  - `cur` is pulse_in directly, and pulse_in must be synchronous to clk_in;
  - there are 2 fewer flops per channel.

## Test plan
- Setup for all scenarios: GATE_CYCLES=100, CHANNELS=2, CNT_WIDTH=4, macro defined.
- Window count: 5 rising pulses on ch0 and 3 on ch1 within window 1, no ack. Required response: at the first `wend`, `valid_out` is 1 and `count_out` is {4'd3, 4'd5}.
- Saturation: 20 rising pulses on ch0 in one window. Required response: `count_out[3:0]` is 15 and `ovf_out` is 2'b01; the next window's count restarts at 0.
- Edge modes: 4 full pulses on ch0 with `edge_sel_in` set to 10, repeated with 11. Required response: counts of 8 and 0 respectively.
- Handshake and overrun:
  - two windows pass with no ack: `overrun_out` is 1 after the second `wend` and `count_out` shows the second window's counts;
  - ack: `valid_out` and `overrun_out` are 0 the next cycle.
- Simultaneous events: `ack_in` is high exactly at `wend` with `valid_out` at 1, and ch0 pulses in the `wend` cycle. Required response: `valid_out` stays 1, `overrun_out` stays 0, and the `wend`-cycle event is included in the new count.
- Reset: rst_in pulses mid-window after 3 counted edges. Required response: all outputs are 0, and the next result reflects only the edges after reset, with `wend` exactly 100 edges after release.
